// File: rtl/seq_stream_ctrl.sv
// Sequencer that streams a latched bit pattern into an external Moore sequence
// detector, counts the detector's hits and records the index of the first one.
module seq_stream_ctrl (
   input  logic        Clock,
   input  logic        Resetn,
   input  logic        start,
   input  logic        abort,
   input  logic [15:0] pattern,
   input  logic [4:0]  length,
   input  logic        z_in,
   output logic        w_out,
   output logic        det_resetn,
   output logic        busy,
   output logic        done,
   output logic [4:0]  hit_count,
   output logic [4:0]  first_hit,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_RUN   = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_e;

   localparam logic [4:0] NO_HIT = 5'd31;

   state_e      state_q, state_d;
   logic [4:0]  idx_q, idx_d;
   logic [4:0]  len_q, len_d;
   logic [4:0]  hit_q, hit_d;
   logic [4:0]  first_q, first_d;
   logic [15:0] pat_q, pat_d;
   logic [4:0]  len_clamp_s;
   logic        sample_s;

   assign len_clamp_s = (length > 5'd16) ? 5'd16 : length;

   // State and datapath registers
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= S_IDLE;
         idx_q   <= 5'd0;
         len_q   <= 5'd0;
         hit_q   <= 5'd0;
         first_q <= NO_HIT;
         pat_q   <= 16'h0000;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         hit_q   <= hit_d;
         first_q <= first_d;
         pat_q   <= pat_d;
      end
   end

   // Next-state, bit index and hit bookkeeping
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      len_d    = len_q;
      hit_d    = hit_q;
      first_d  = first_q;
      pat_d    = pat_q;
      sample_s = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               pat_d   = pattern;
               len_d   = len_clamp_s;
               hit_d   = 5'd0;
               first_d = NO_HIT;
               idx_d   = 5'd0;
               state_d = (len_clamp_s == 5'd0) ? S_DONE : S_CLEAR;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CLEAR: begin
            idx_d   = 5'd0;
            state_d = abort ? S_IDLE : S_RUN;
         end
         S_RUN: begin
            if (abort) begin
               idx_d   = 5'd0;
               state_d = S_IDLE;
            end else begin
               // z_in seen at idx reflects the detector having consumed bit idx-1
               sample_s = (idx_q != 5'd0);
               idx_d    = idx_q + 5'd1;
               state_d  = (idx_q == len_q - 5'd1) ? S_DRAIN : S_RUN;
            end
         end
         S_DRAIN: begin
            if (abort) begin
               idx_d   = 5'd0;
               state_d = S_IDLE;
            end else begin
               sample_s = 1'b1;
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            idx_d   = 5'd0;
            state_d = S_IDLE;
         end
         default: begin
            idx_d   = 5'd0;
            state_d = S_IDLE;
         end
      endcase

      if (sample_s && z_in) begin
         hit_d = hit_q + 5'd1;
         if (first_q == NO_HIT) begin
            first_d = idx_q - 5'd1;
         end else begin
            first_d = first_q;
         end
      end else begin
         hit_d = hit_d;
      end
   end

   assign w_out      = (state_q == S_RUN) ? pat_q[idx_q[3:0]] : 1'b0;
   assign det_resetn = (state_q != S_CLEAR);
   assign busy       = (state_q == S_CLEAR) || (state_q == S_RUN) || (state_q == S_DRAIN);
   assign done       = (state_q == S_DONE);
   assign hit_count  = hit_q;
   assign first_hit  = first_q;
   assign state      = state_q;

endmodule

// File: tb/tb_seq_stream_ctrl.sv
// Bench for seq_stream_ctrl: behavioural four-equal-bits detector on z_in,
// scoreboard of expected run results pushed at start and popped at done.
module tb_seq_stream_ctrl;

   logic        Clock = 1'b0;
   logic        Resetn;
   logic        start;
   logic        abort;
   logic [15:0] pattern;
   logic [4:0]  length;
   logic        z_in;
   logic        w_out;
   logic        det_resetn;
   logic        busy;
   logic        done;
   logic [4:0]  hit_count;
   logic [4:0]  first_hit;
   logic [2:0]  state;

   typedef struct {
      logic [4:0] hit;
      logic [4:0] first;
   } exp_t;

   exp_t sb_q[$];
   logic w_q[$];
   exp_t last_exp;
   int   tests = 0;
   int   fails = 0;

   seq_stream_ctrl dut (
      .Clock(Clock), .Resetn(Resetn), .start(start), .abort(abort),
      .pattern(pattern), .length(length), .z_in(z_in), .w_out(w_out),
      .det_resetn(det_resetn), .busy(busy), .done(done),
      .hit_count(hit_count), .first_hit(first_hit), .state(state)
   );

   always #5 Clock = ~Clock;

   // Detector model: z=1 once the last four w bits since reset are all equal
   logic [3:0] hist;
   int         hcnt;
   always @(posedge Clock or negedge Resetn) begin
      if (!Resetn || !det_resetn) begin
         hist <= 4'h0;
         hcnt <= 0;
      end else begin
         hist <= {hist[2:0], w_out};
         if (hcnt < 4) hcnt <= hcnt + 1;
      end
   end
   assign z_in = (hcnt >= 4) && ((hist == 4'hF) || (hist == 4'h0));

   // Reference: a detection completes at bit j when bits j-3..j are all equal
   function automatic void ref_run(input logic [15:0] p, input int l,
                                   output logic [4:0] h, output logic [4:0] f);
      int lc;
      lc = (l > 16) ? 16 : l;
      h = 5'd0;
      f = 5'd31;
      for (int j = 3; j < lc; j++) begin
         if ((p[j -: 4] == 4'h0) || (p[j -: 4] == 4'hF)) begin
            h = h + 5'd1;
            if (f == 5'd31) f = 5'(j);
         end
      end
   endfunction

   task automatic check_reset_outputs(input string tag);
      tests++;
      if (state !== 3'd0 || w_out !== 1'b0 || det_resetn !== 1'b1 || busy !== 1'b0 ||
          done !== 1'b0 || hit_count !== 5'd0 || first_hit !== 5'd31) begin
         fails++;
         $display("FAIL %s: state=%0d w=%b drst=%b busy=%b done=%b hit=%0d first=%0d, required 0 0 1 0 0 0 31",
                  tag, state, w_out, det_resetn, busy, done, hit_count, first_hit);
      end
   endtask

   task automatic test_reset();
      Resetn = 1'b0; start = 1'b0; abort = 1'b0; pattern = 16'h0; length = 5'd0;
      #12;
      check_reset_outputs("reset");
      @(negedge Clock);
      Resetn = 1'b1;
      @(negedge Clock);
      check_reset_outputs("idle_after_reset");
   endtask

   task automatic run_and_check(input logic [15:0] p, input logic [4:0] l, input string tag);
      int lc, lat, busy_n, drst_n;
      logic wexp;
      exp_t e;
      logic [4:0] h, f;
      lc = (l > 5'd16) ? 16 : int'(l);
      ref_run(p, int'(l), h, f);
      e.hit = h; e.first = f;
      sb_q.push_back(e);
      w_q.delete();
      for (int i = 0; i < lc; i++) w_q.push_back(p[i]);
      lat = -1; busy_n = 0; drst_n = 0;
      @(negedge Clock);
      start = 1'b1; pattern = p; length = l;
      for (int k = 0; k < 40; k++) begin
         @(negedge Clock);
         if (k == 0) start = 1'b0;
         if (busy) busy_n++;
         if (!det_resetn) drst_n++;
         if (state == 3'd2) begin
            tests++;
            if (w_q.size() == 0) begin
               fails++;
               $display("FAIL %s_w: extra RUN cycle, w=%b, required no RUN", tag, w_out);
            end else begin
               wexp = w_q.pop_front();
               if (w_out !== wexp) begin
                  fails++;
                  $display("FAIL %s_w: w_out=%b, required %b", tag, w_out, wexp);
               end
            end
         end else if (state == 3'd1 || state == 3'd3) begin
            tests++;
            if (w_out !== 1'b0) begin
               fails++;
               $display("FAIL %s_w0: w_out=%b in state %0d, required 0", tag, w_out, state);
            end
         end
         if (done) begin
            lat = k + 1;   // edges after the start edge up to the one sampling done=1
            break;
         end
      end
      tests++;
      if (lat != ((lc == 0) ? 1 : lc + 3)) begin
         fails++;
         $display("FAIL %s_latency: %0d, required %0d (-1 = timeout)", tag, lat, (lc == 0) ? 1 : lc + 3);
      end
      tests++;
      if (busy_n != ((lc == 0) ? 0 : lc + 2) || drst_n != ((lc == 0) ? 0 : 1) || w_q.size() != 0) begin
         fails++;
         $display("FAIL %s_cycles: busy=%0d drst_low=%0d w_left=%0d, required %0d %0d 0",
                  tag, busy_n, drst_n, w_q.size(), (lc == 0) ? 0 : lc + 2, (lc == 0) ? 0 : 1);
      end
      @(negedge Clock);
      tests++;
      if (done !== 1'b0 || state !== 3'd0) begin
         fails++;
         $display("FAIL %s_pulse: done=%b state=%0d, required 0 0", tag, done, state);
      end
      e = sb_q.pop_front();
      last_exp = e;
      tests++;
      if (hit_count !== e.hit || first_hit !== e.first) begin
         fails++;
         $display("FAIL %s_result: hit=%0d first=%0d, required %0d %0d",
                  tag, hit_count, first_hit, e.hit, e.first);
      end
   endtask

   task automatic test_spec_scenarios();
      run_and_check(16'h000F, 5'd8, "p000f");
      tests++;
      if (last_exp.hit != 5'd2 || last_exp.first != 5'd3) begin
         fails++;
         $display("FAIL ref_model: hit=%0d first=%0d, required 2 3", last_exp.hit, last_exp.first);
      end
      run_and_check(16'hFFFF, 5'd6,  "pffff");
      run_and_check(16'h5555, 5'd16, "p5555");
      run_and_check(16'h1234, 5'd0,  "len0");
   endtask

   task automatic test_clamp();
      run_and_check(16'hFFFF, 5'd31, "clamp31");
      run_and_check(16'h00F0, 5'd20, "clamp20");
   endtask

   task automatic test_back_to_back();
      run_and_check(16'h0001, 5'd1,  "len1");
      run_and_check(16'hF0F0, 5'd12, "b2b");
   endtask

   task automatic test_hold();
      repeat (3) @(negedge Clock);
      tests++;
      if (hit_count !== last_exp.hit || first_hit !== last_exp.first) begin
         fails++;
         $display("FAIL hold: hit=%0d first=%0d, required %0d %0d",
                  hit_count, first_hit, last_exp.hit, last_exp.first);
      end
   endtask

   task automatic test_abort();
      exp_t e;
      logic [4:0] h, f;
      int run_n, done_n;
      logic wexp;
      ref_run(16'h0010, 5, h, f);   // bits 0..4 consumed before the abort edge
      e.hit = h; e.first = f;
      sb_q.push_back(e);
      w_q.delete();
      for (int i = 0; i < 16; i++) w_q.push_back(1'((16'h0010 >> i) & 16'h1));
      run_n = 0;
      @(negedge Clock);
      start = 1'b1; pattern = 16'h0010; length = 5'd16;
      for (int k = 0; k < 40; k++) begin
         @(negedge Clock);
         if (k == 0) start = 1'b0;
         if (state == 3'd2) begin
            wexp = w_q.pop_front();
            tests++;
            if (w_out !== wexp) begin
               fails++;
               $display("FAIL abort_w: w_out=%b, required %b", w_out, wexp);
            end
            if (run_n == 2) begin start = 1'b1; pattern = 16'hFFFF; length = 5'd3; end
            if (run_n == 3) start = 1'b0;
            if (run_n == 5) begin abort = 1'b1; break; end
            run_n++;
         end
      end
      @(negedge Clock);
      abort = 1'b0;
      e = sb_q.pop_front();
      tests++;
      if (state !== 3'd0 || done !== 1'b0 || busy !== 1'b0 || hit_count !== e.hit || first_hit !== e.first) begin
         fails++;
         $display("FAIL abort: state=%0d done=%b busy=%b hit=%0d first=%0d, required 0 0 0 %0d %0d",
                  state, done, busy, hit_count, first_hit, e.hit, e.first);
      end
      done_n = 0;
      repeat (5) begin
         @(negedge Clock);
         if (done || state != 3'd0) done_n++;
      end
      tests++;
      if (done_n != 0) begin
         fails++;
         $display("FAIL abort_quiet: %0d cycles with done or non-IDLE, required 0", done_n);
      end
      w_q.delete();
   endtask

   task automatic test_reset_midrun();
      int run_n;
      run_n = 0;
      @(negedge Clock);
      start = 1'b1; pattern = 16'h000F; length = 5'd8;
      for (int k = 0; k < 40; k++) begin
         @(negedge Clock);
         if (k == 0) start = 1'b0;
         if (state == 3'd2) run_n++;
         if (run_n == 6) break;
      end
      #2 Resetn = 1'b0;
      #1 check_reset_outputs("reset_midrun");
      @(negedge Clock);
      Resetn = 1'b1;
      run_and_check(16'h000F, 5'd8, "after_reset");
   endtask

   initial begin
      test_reset();
      test_spec_scenarios();
      test_hold();
      test_clamp();
      test_back_to_back();
      test_abort();
      test_reset_midrun();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
